// File: rtl/iommu_field_pkg.sv
// Shared types and defaults for the IOMMU register-field helpers.
package iommu_field_pkg;

  typedef enum logic {HW_SCHED_IDLE, HW_SCHED_ISSUE} hw_sched_state_e;

  localparam int RETRY_MAX_DEFAULT = 8;

endpackage

// File: rtl/iommu_rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping modulo N.
module iommu_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  int cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand[$clog2(N)-1:0];
      end
    end
  end

endmodule

// File: rtl/iommu_field_hw_sched.sv
// Shares one field's HW update port between N_REQ requesters using masked read-modify-write,
// replaying an update whenever a SW write collides with it.
module iommu_field_hw_sched
  import iommu_field_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RETRY_MAX  = RETRY_MAX_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] mask_i,
  input  logic                        we_i,
  input  logic [DATA_WIDTH-1:0]       q_i,
  output logic                        de_o,
  output logic [DATA_WIDTH-1:0]       d_o,
  output logic [N_REQ-1:0]            gnt_o,
  output logic                        stall_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(RETRY_MAX + 1);

  hw_sched_state_e state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]         coll_q, coll_d;
  logic                  stall_q, stall_d;

  logic [N_REQ-1:0] idx_onehot;
  logic [IW-1:0]    next_ptr;
  logic [N_REQ-1:0] pick_req;
  logic [IW-1:0]    pick_ptr;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign next_ptr   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  // While issuing, the current owner is excluded and the search starts where rr_ptr is headed.
  always_comb begin
    pick_req = req_i;
    pick_ptr = rr_ptr_q;
    if (state_q == HW_SCHED_ISSUE) begin
      pick_req = req_i & ~idx_onehot;
      pick_ptr = next_ptr;
    end
  end

  iommu_rr_picker #(.N(N_REQ)) u_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    data_d   = data_q;
    mask_d   = mask_q;
    coll_d   = coll_q;
    de_o     = 1'b0;
    d_o      = '0;
    gnt_o    = '0;
    unique case (state_q)
      HW_SCHED_IDLE: begin
        if (pick_valid) begin
          state_d = HW_SCHED_ISSUE;
          idx_d   = pick_idx;
          data_d  = data_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          mask_d  = mask_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      HW_SCHED_ISSUE: begin
        de_o = 1'b1;
        d_o  = (q_i & ~mask_q) | (data_q & mask_q);
        if (!we_i) begin
          gnt_o    = idx_onehot;
          rr_ptr_d = next_ptr;
          coll_d   = '0;
          if (pick_valid) begin
            idx_d  = pick_idx;
            data_d = data_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            mask_d = mask_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            state_d = HW_SCHED_IDLE;
          end
        end else if (coll_q < CW'(RETRY_MAX)) begin
          coll_d = coll_q + 1'b1;
        end
      end
      default: state_d = HW_SCHED_IDLE;
    endcase
    stall_d = (coll_d >= CW'(RETRY_MAX));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HW_SCHED_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      coll_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      coll_q   <= coll_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: tb/tb_iommu_field_hw_sched.sv
// Directed self-checking bench for iommu_field_hw_sched (4 requesters, RETRY_MAX=3).
module tb_iommu_field_hw_sched;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N*DW-1:0] mask_i;
  logic            we_i;
  logic [DW-1:0]   q_i;
  logic            de_o;
  logic [DW-1:0]   d_o;
  logic [N-1:0]    gnt_o;
  logic            stall_o;

  int checks = 0;
  int errors = 0;

  iommu_field_hw_sched #(.N_REQ(N), .DATA_WIDTH(DW), .RETRY_MAX(3)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .data_i  (data_i),
    .mask_i  (mask_i),
    .we_i    (we_i),
    .q_i     (q_i),
    .de_o    (de_o),
    .d_o     (d_o),
    .gnt_o   (gnt_o),
    .stall_o (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic applyStimulus(input logic [N-1:0] req, input logic we, input logic [DW-1:0] q);
    @(posedge clk_i);
    #1;
    req_i = req;
    we_i  = we;
    q_i   = q;
    @(negedge clk_i);
  endtask

  task automatic expectCycle(input string tag, input logic de, input logic [N-1:0] gnt, input logic stall);
    checkOutput({tag, ".de"}, 32'(de_o), 32'(de));
    checkOutput({tag, ".gnt"}, 32'(gnt_o), 32'(gnt));
    checkOutput({tag, ".stall"}, 32'(stall_o), 32'(stall));
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i  = '0;
    we_i   = 1'b0;
    q_i    = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = '0;
    we_i   = 1'b0;
    q_i    = '0;
    data_i = '0;
    mask_i = '0;

    // Reset state
    doReset();
    expectCycle("reset", 1'b0, 4'b0000, 1'b0);
    checkOutput("reset.d", d_o, 32'h0);

    // Single requester, then an empty mask
    data_i[1*DW +: DW] = 32'h0000_00AB;
    mask_i[1*DW +: DW] = 32'h0000_00FF;
    applyStimulus(4'b0010, 1'b0, 32'h1234_5600);
    expectCycle("single.c0", 1'b0, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0, 32'h1234_5600);
    expectCycle("single.c1", 1'b1, 4'b0010, 1'b0);
    checkOutput("single.d", d_o, 32'h1234_56AB);
    applyStimulus(4'b0000, 1'b0, 32'h1234_5600);
    expectCycle("single.c2", 1'b0, 4'b0000, 1'b0);
    data_i[0*DW +: DW] = 32'hFFFF_FFFF;
    mask_i[0*DW +: DW] = 32'h0000_0000;
    applyStimulus(4'b0001, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(4'b0001, 1'b0, 32'hDEAD_BEEF);
    expectCycle("mask0", 1'b1, 4'b0001, 1'b0);
    checkOutput("mask0.d", d_o, 32'hDEAD_BEEF);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    // All four at once from rr_ptr=0
    doReset();
    for (int i = 0; i < N; i++) begin
      data_i[i*DW +: DW] = 32'hA5A5_A5A5;
      mask_i[i*DW +: DW] = 32'h0000_00FF << (8 * i);
    end
    applyStimulus(4'b1111, 1'b0, 32'h0);
    expectCycle("all.c0", 1'b0, 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 32'h0);
    expectCycle("all.c1", 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b1110, 1'b0, 32'h0);
    expectCycle("all.c2", 1'b1, 4'b0010, 1'b0);
    checkOutput("all.d1", d_o, 32'h0000_A500);
    applyStimulus(4'b1100, 1'b0, 32'h0);
    expectCycle("all.c3", 1'b1, 4'b0100, 1'b0);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    expectCycle("all.c4", 1'b1, 4'b1000, 1'b0);
    checkOutput("all.d3", d_o, 32'hA500_0000);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    expectCycle("all.c5", 1'b0, 4'b0000, 1'b0);
    // rr_ptr wrapped to 0, so requester 0 beats requester 3
    applyStimulus(4'b1001, 1'b0, 32'h0);
    applyStimulus(4'b1001, 1'b0, 32'h0);
    expectCycle("wrap", 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    expectCycle("wrap.next", 1'b1, 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    // SW collision replays with the post-SW field value
    doReset();
    data_i[2*DW +: DW] = 32'h1234_5678;
    mask_i[2*DW +: DW] = 32'h0000_FFFF;
    applyStimulus(4'b0100, 1'b0, 32'h0);
    applyStimulus(4'b0100, 1'b1, 32'h0);
    expectCycle("coll.c1", 1'b1, 4'b0000, 1'b0);
    checkOutput("coll.d1", d_o, 32'h0000_5678);
    applyStimulus(4'b0100, 1'b0, 32'hF000_0000);
    expectCycle("coll.c2", 1'b1, 4'b0100, 1'b0);
    checkOutput("coll.d2", d_o, 32'hF000_5678);
    applyStimulus(4'b0000, 1'b0, 32'hF000_0000);

    // Starvation: three collisions raise stall, a commit clears it
    doReset();
    data_i[3*DW +: DW] = 32'h0000_0000;
    mask_i[3*DW +: DW] = 32'hFFFF_0000;
    applyStimulus(4'b1000, 1'b0, 32'h0);
    applyStimulus(4'b1000, 1'b1, 32'h0);
    expectCycle("starve.c1", 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1, 32'h0);
    expectCycle("starve.c2", 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1, 32'h0);
    expectCycle("starve.c3", 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b0, 32'h0);
    expectCycle("starve.c4", 1'b1, 4'b1000, 1'b1);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    expectCycle("starve.c5", 1'b0, 4'b0000, 1'b0);

    // Fairness: requesters 0 and 2 keep coming back
    doReset();
    applyStimulus(4'b0101, 1'b0, 32'h0);
    applyStimulus(4'b0101, 1'b0, 32'h0);
    expectCycle("fair.g0", 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    expectCycle("fair.g1", 1'b1, 4'b0100, 1'b0);
    applyStimulus(4'b0101, 1'b0, 32'h0);
    expectCycle("fair.idle", 1'b0, 4'b0000, 1'b0);
    applyStimulus(4'b0101, 1'b0, 32'h0);
    expectCycle("fair.g2", 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    expectCycle("fair.g3", 1'b1, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0, 32'h0);

    // Asynchronous reset while stalled in ISSUE
    doReset();
    applyStimulus(4'b0010, 1'b0, 32'h0);
    applyStimulus(4'b0110, 1'b0, 32'h0);
    expectCycle("rst.g1", 1'b1, 4'b0010, 1'b0);
    applyStimulus(4'b0100, 1'b1, 32'h0);
    applyStimulus(4'b0100, 1'b1, 32'h0);
    applyStimulus(4'b0100, 1'b1, 32'h0);
    applyStimulus(4'b0100, 1'b1, 32'h0);
    expectCycle("rst.pre", 1'b1, 4'b0000, 1'b1);
    #2;
    rst_ni = 1'b0;
    req_i  = 4'b0101;
    we_i   = 1'b0;
    #1;
    expectCycle("rst.async", 1'b0, 4'b0000, 1'b0);
    checkOutput("rst.async.d", d_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(4'b0101, 1'b0, 32'h0);
    expectCycle("rst.after0", 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b0, 32'h0);
    expectCycle("rst.after1", 1'b1, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0, 32'h0);
    expectCycle("rst.done", 1'b0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
